// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage feeding the decoder. Holds a word-addressed instruction memory,
//   a fetch program counter and an IDLE/RUN/HALT controller. While running it
//   presents one registered instruction per un-stalled cycle, together with its
//   byte address and the decoder field slices.
//
// Ports
//   clk          in   rising-edge clock for all state
//   reset        in   synchronous, active-high
//   load_en      in   write load_data into imem[load_addr] (IDLE only)
//   load_addr    in   word index into imem
//   load_data    in   instruction word to store
//   start        in   IDLE->RUN, HALT->IDLE
//   stall        in   freeze fetch this cycle (RUN only)
//   instr        out  current instruction (registered)
//   pc           out  byte address of instr
//   instr_valid  out  instr and fields hold a fetched instruction
//   Op/funct3/funct7/rd/rs1/rs2  out  slices of instr
//   halt         out  high while in HALT
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          stall,
  output logic [31:0]   instr,
  output logic [31:0]   pc,
  output logic          instr_valid,
  output logic [6:0]    Op,
  output logic [2:0]    funct3,
  output logic [6:0]    funct7,
  output logic [4:0]    rd,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  output logic          halt
);

  // Low two bits of the start address are forced to zero (word aligned).
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_d;
  logic [31:0]   instr_q;
  logic [31:0]   pc_q;
  logic          instr_valid_q;
  logic          halt_q;

  logic [31:0]   imem [IMEM_DEPTH];
  logic [AW-1:0] fetch_idx;
  logic [31:0]   fetch_word;
  logic          halt_hit;

  assign fetch_idx  = fetch_pc_q[AW+1:2];
  assign fetch_word = imem[fetch_idx];
  assign fetch_pc_d = fetch_pc_q + 32'd4;

  // Stop on the ecall word, or on the last memory slot so fetch never wraps.
  assign halt_hit = (fetch_word == HALT_INSTR) ||
                    (fetch_idx == AW'(IMEM_DEPTH - 1));

  // Memory is only writable from IDLE; reset suppresses the write too.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ST_IDLE) && load_en) begin
      imem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= START_PC;
      instr_q       <= 32'h0;
      pc_q          <= 32'h0;
      instr_valid_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            instr_q       <= fetch_word;
            pc_q          <= fetch_pc_q;
            instr_valid_q <= 1'b1;
            if (halt_hit) begin
              // Final word is still presented; fetch_pc stays put.
              state_q <= ST_HALT;
              halt_q  <= 1'b1;
            end else begin
              fetch_pc_q <= fetch_pc_d;
            end
          end
        end
        ST_HALT: begin
          instr_valid_q <= 1'b0;
          if (start) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= START_PC;
            halt_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign halt        = halt_q;

  assign Op     = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;

  logic [31:0] instr, pc;
  logic        instr_valid, halt;
  logic [6:0]  Op, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  logic [31:0] instr_s, pc_s;
  logic        instr_valid_s, halt_s;
  logic [6:0]  Op_s, funct7_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.IMEM_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall),
    .instr(instr), .pc(pc), .instr_valid(instr_valid),
    .Op(Op), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .halt(halt)
  );

  // Small-memory instance shares the stimulus; only checked in test 4.
  instr_fetch_unit #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr[1:0]),
    .load_data(load_data), .start(start), .stall(stall),
    .instr(instr_s), .pc(pc_s), .instr_valid(instr_valid_s),
    .Op(Op_s), .funct3(funct3_s), .funct7(funct7_s), .rd(rd_s), .rs1(rs1_s), .rs2(rs2_s),
    .halt(halt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // Advance one edge; outputs are stable 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2;
    // ---- Test 1: reset state, single R-type fetch and field split ----
    do_reset();
    chk("t1_rst_valid", 32'(instr_valid), 32'd0);
    chk("t1_rst_pc", pc, 32'h0);
    chk("t1_rst_instr", instr, 32'h0);
    chk("t1_rst_halt", 32'(halt), 32'd0);
    chk("t1_rst_op", 32'(Op), 32'h0);
    load(6'd0, 32'h002081B3);
    go();
    chk("t1_edgeN_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_pc", pc, 32'h0);
    chk("t1_op", 32'(Op), 32'h33);
    chk("t1_funct3", 32'(funct3), 32'd0);
    chk("t1_funct7", 32'(funct7), 32'd0);
    chk("t1_rd", 32'(rd), 32'd3);
    chk("t1_rs1", 32'(rs1), 32'd1);
    chk("t1_rs2", 32'(rs2), 32'd2);

    // ---- Test 2: three-word program ending in ecall ----
    do_reset();
    load(6'd0, 32'h002081B3);
    load(6'd1, 32'h40208233);
    load(6'd2, 32'h00000073);
    go();
    tick();
    chk("t2_pc0", pc, 32'h0);
    chk("t2_instr0", instr, 32'h002081B3);
    tick();
    chk("t2_pc4", pc, 32'h4);
    chk("t2_funct7", 32'(funct7), 32'h20);
    tick();
    chk("t2_pc8", pc, 32'h8);
    chk("t2_ecall_valid", 32'(instr_valid), 32'd1);
    chk("t2_ecall_instr", instr, 32'h00000073);
    tick();
    chk("t2_halt", 32'(halt), 32'd1);
    chk("t2_halt_valid", 32'(instr_valid), 32'd0);
    chk("t2_halt_pc_hold", pc, 32'h8);

    // ---- Test 3: stall holds presented instruction ----
    do_reset();
    load(6'd0, 32'h002081B3);
    load(6'd1, 32'h40208233);
    load(6'd2, 32'h00000073);
    go();
    tick();
    tick();
    chk("t3_pc4", pc, 32'h4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_stall%0d_pc", i), pc, 32'h4);
      chk($sformatf("t3_stall%0d_instr", i), instr, 32'h40208233);
    end
    stall = 1'b0;
    tick();
    chk("t3_release_pc", pc, 32'h8);

    // ---- Test 4: depth-4 memory with no ecall stops at the last slot ----
    do_reset();
    load(6'd0, 32'h002081B3);
    load(6'd1, 32'h40208233);
    load(6'd2, 32'h002081B3);
    load(6'd3, 32'h40208233);
    go();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_pc%0d", i), pc_s, 32'(4 * i));
      chk($sformatf("t4_valid%0d", i), 32'(instr_valid_s), 32'd1);
    end
    tick();
    chk("t4_halt", 32'(halt_s), 32'd1);
    chk("t4_halt_valid", 32'(instr_valid_s), 32'd0);
    tick();
    chk("t4_nowrap_pc", pc_s, 32'hC);

    // ---- Test 5: loads during RUN ignored; re-run after HALT ----
    do_reset();
    load(6'd0, 32'h002081B3);
    load(6'd1, 32'h00000073);
    go();
    load_en   = 1'b1;
    load_addr = 6'd0;
    load_data = 32'hFFFFFFFF;
    tick();
    chk("t5_run_instr0", instr, 32'h002081B3);
    tick();
    chk("t5_ecall", instr, 32'h00000073);
    load_en = 1'b0;
    tick();
    chk("t5_halt", 32'(halt), 32'd1);
    go();
    chk("t5_idle_halt", 32'(halt), 32'd0);
    chk("t5_idle_valid", 32'(instr_valid), 32'd0);
    go();
    tick();
    chk("t5_rerun_pc", pc, 32'h0);
    chk("t5_rerun_instr", instr, 32'h002081B3);

    // ---- Test 6: synchronous reset mid-run ----
    do_reset();
    load(6'd0, 32'h002081B3);
    load(6'd1, 32'h40208233);
    load(6'd2, 32'h002081B3);
    load(6'd3, 32'h40208233);
    go();
    tick();
    tick();
    tick();
    chk("t6_pc8", pc, 32'h8);
    do_reset();
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_halt", 32'(halt), 32'd0);
    go();
    tick();
    chk("t6_restart_pc", pc, 32'h0);
    chk("t6_restart_instr", instr, 32'h002081B3);
    tick();
    chk("t6_restart_instr1", instr, 32'h40208233);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
